// File: rtl/game_controller.sv
// game_controller: match FSM for scoring, serve timing and freeze/reset of ball and paddles (optional pause via GAME_CTRL_PAUSE_EN)
module game_controller #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       vs_in,
  input  logic       start,
  input  logic       pause,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic       round_rst,
  output logic       done,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       match_over,
  output logic [1:0] winner,
  output logic       serve_dir,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAMEOVER, PAUSED} st_t;
  localparam logic [3:0] WS = 4'(WIN_SCORE);
  localparam logic [7:0] SL = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] PL = 8'(POINT_FRAMES - 1);
  st_t cur, nxt;
  logic [2:0] start_sh;
  logic [1:0] vs_sh;
  logic [7:0] cnt;
  logic start_p, pause_p, tick, win1, win2, p1_only, p2_only;
  assign start_p = start_sh[1] & ~start_sh[2];
  assign tick    = vs_sh[1] & ~vs_sh[0];
  assign win1    = p1_score == WS;
  assign win2    = p2_score == WS;
  assign p1_only = p1_win & ~p2_win;
  assign p2_only = p2_win & ~p1_win;
  assign state   = cur;
`ifdef GAME_CTRL_PAUSE_EN
  logic [2:0] pause_sh;
  assign pause_p = pause_sh[1] & ~pause_sh[2];
  // pause button synchronizer and edge history
  always_ff @(posedge vga_clk or negedge rst)
    if (!rst) pause_sh <= '0;
    else pause_sh <= {pause_sh[1:0], pause};
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_p = 1'b0;
`endif
  // next-state decode; a scored point beats a simultaneous pause
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:     nxt = start_p ? SERVE : IDLE;
      SERVE:    nxt = (tick && cnt == SL) ? PLAY : SERVE;
      PLAY:     nxt = (p1_win | p2_win) ? POINT : pause_p ? PAUSED : PLAY;
      POINT:    nxt = (tick && cnt == PL) ? ((win1 | win2) ? GAMEOVER : SERVE) : POINT;
      GAMEOVER: nxt = start_p ? IDLE : GAMEOVER;
      PAUSED:   nxt = pause_p ? PLAY : PAUSED;
      default:  nxt = IDLE;
    endcase
  end
  // state, synchronizers, frame counter, scores and registered outputs
  always_ff @(posedge vga_clk or negedge rst)
    if (!rst) begin
      cur        <= IDLE;
      start_sh   <= '0;
      vs_sh      <= '0;
      cnt        <= '0;
      p1_score   <= '0;
      p2_score   <= '0;
      serve_dir  <= 1'b0;
      round_rst  <= 1'b0;
      done       <= 1'b1;
      match_over <= 1'b0;
      winner     <= 2'b00;
    end else begin
      cur        <= nxt;
      start_sh   <= {start_sh[1:0], start};
      vs_sh      <= {vs_sh[0], vs_in};
      cnt        <= (cur != nxt) ? 8'd0 : (tick && (cur == SERVE || cur == POINT)) ? cnt + 8'd1 : cnt;
      p1_score   <= (cur == IDLE && start_p) ? 4'd0 : (cur == PLAY && p1_only && !win1) ? p1_score + 4'd1 : p1_score;
      p2_score   <= (cur == IDLE && start_p) ? 4'd0 : (cur == PLAY && p2_only && !win2) ? p2_score + 4'd1 : p2_score;
      serve_dir  <= (cur == PLAY && p1_only) ? 1'b1 : (cur == PLAY && p2_only) ? 1'b0 : serve_dir;
      round_rst  <= nxt != IDLE && !(cur == POINT && nxt == SERVE);
      done       <= nxt != PLAY;
      match_over <= nxt == GAMEOVER;
      winner     <= (nxt == GAMEOVER) ? {win2, win1} : 2'b00;
    end
endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter WIN_SCORE, default 5, points needed to win the match (legal range 1..15).
REQ-002 Parameter SERVE_FRAMES, default 60, frozen frames before play resumes (legal range 1..255).
REQ-003 Parameter POINT_FRAMES, default 90, frozen frames showing a scored point (legal range 1..255).
REQ-004 vga_clk  in  1  single clock for the block.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 vs_in  in  1  vertical sync from the sync generator; its falling edge defines one frame tick.
REQ-007 start  in  1  raw start pushbutton, asynchronous and active-high.
REQ-008 pause  in  1  raw pause pushbutton, asynchronous and active-high; used only when GAME_CTRL_PAUSE_EN is defined.
REQ-009 p1_win, p2_win  in  1 each  point-scored levels from the ball; each stays high until the ball is reset.
REQ-010 round_rst  out  1  active-low reset to the ball and both paddles.
REQ-011 done  out  1  freeze, active-high, to the ball and paddles.
REQ-012 p1_score, p2_score  out  4 each  current scores.
REQ-013 match_over  out  1  high in the GAMEOVER state.
REQ-014 winner  out  2  00 none, 01 P1, 10 P2.
REQ-015 serve_dir  out  1  0 serve toward P1, 1 serve toward P2.
REQ-016 state  out  3  encoded FSM state, for debug.

Function
REQ-017 start and pause SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector, giving a one-cycle pulse.
REQ-018 vs_in SHALL be registered; a frame tick is a 1-to-0 transition, one cycle wide.
REQ-019 The FSM SHALL have these states and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4, PAUSED=5.
REQ-020 IDLE: round_rst=0 and done=1; on a start pulse, clear both scores and go to SERVE.
REQ-021 SERVE: round_rst=1 and done=1; the frame counter is cleared on entry; on the frame tick with count==SERVE_FRAMES-1, go to PLAY.
REQ-022 PLAY: done=0; p1_win and p2_win are sampled every cycle.
REQ-023 PLAY, p1_win alone: p1_score increments and the FSM goes to POINT; p2_win alone: same for p2_score.
REQ-024 PLAY, p1_win and p2_win in the same cycle: no score change, go to POINT, serve_dir unchanged.
REQ-025 On a scored point, serve_dir SHALL be set toward the player who lost the point.
REQ-026 POINT: done=1; on the frame tick with count==POINT_FRAMES-1, go to GAMEOVER if either score==WIN_SCORE, else to SERVE.
REQ-027 On the POINT->SERVE transition, round_rst SHALL be 0 for exactly one cycle.
REQ-028 GAMEOVER: done=1, round_rst=1, match_over=1, winner set to the player whose score==WIN_SCORE; on a start pulse, go to IDLE with winner=00.
REQ-029 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-030 A start pulse in SERVE, PLAY or POINT SHALL be ignored.
REQ-031 All outputs SHALL be registered; every output reflects a state change in the first cycle after the transition edge.
REQ-032 A frame tick coinciding with a state entry SHALL NOT count toward the new state's frame count.

Reset
REQ-033 While rst=0, the block SHALL asynchronously force: state=IDLE, scores=0, round_rst=0, done=1, match_over=0, winner=00, serve_dir=0, frame counter=0, synchronizers=0.
REQ-034 Reset asserted mid-match SHALL abandon the match; after release, play restarts only on a new start pulse.

Configuration
REQ-035 GAME_CTRL_PAUSE_EN defined: a pause pulse in PLAY goes to PAUSED (done=1, round_rst=1); a pause pulse in PAUSED returns to PLAY.
REQ-036 GAME_CTRL_PAUSE_EN defined: PAUSED ignores p1_win, p2_win and start, and the frame counter holds.
REQ-037 GAME_CTRL_PAUSE_EN undefined: the pause port stays present but is ignored, and PAUSED is unreachable.

Verification
REQ-038 WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=3. Release reset, pulse start -> round_rst goes 1 next cycle; done=1 for 2 frame ticks; then state=PLAY and done=0.
REQ-039 In PLAY, raise p1_win -> p1_score=1, serve_dir=1, state=POINT. After 3 ticks -> one-cycle round_rst=0, state=SERVE.
REQ-040 In PLAY, raise p1_win and p2_win in the same cycle -> scores unchanged, state=POINT, serve_dir unchanged.
REQ-041 Score P2 three times -> after the third POINT window, state=GAMEOVER, winner=10, match_over=1. A further p2_win -> p2_score stays 3. Pulse start -> state=IDLE, winner=00.
REQ-042 Assert rst during POINT with scores 2:1 -> all outputs at reset values immediately, with no clock edge needed.
REQ-043 GAME_CTRL_PAUSE_EN defined, in PLAY: pulse pause -> done=1 and p1_win is ignored. Pulse pause again -> PLAY, and the next p1_win is scored.
